// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch (read-only) and data (read/write) requesters.
// Optional macro UMA_ROUND_ROBIN_EN replaces fixed data-over-fetch priority with a 1-bit round-robin pointer.
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [ADDR_W-1:0]     f_addr,
  output logic [DATA_W-1:0]     f_rdata,
  output logic                  f_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_valid,
  output logic                  stall_F,
  output logic                  stall_M,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DATA_W/8-1:0]   m_be,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  err
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, F_ACC, D_ACC, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             grant_d;

  assign stall_F = f_req & ~f_valid;
  assign stall_M = d_req & ~d_valid;

`ifdef UMA_ROUND_ROBIN_EN
  // rr_d set: data wins a tie (fetch was granted last, or fresh out of reset)
  logic rr_d;
  assign grant_d = d_req & (~f_req | rr_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            rr_d <= 1'b1;
    else if (state == IDLE && (d_req | f_req)) rr_d <= ~grant_d;
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      f_rdata <= '0;
      d_rdata <= '0;
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req | f_req) begin
            m_req   <= 1'b1;
            m_addr  <= grant_d ? d_addr : f_addr;
            m_we    <= grant_d & d_we;
            m_be    <= grant_d ? d_be : BE_W'(0);
            m_wdata <= grant_d ? d_wdata : DATA_W'(0);
            cnt     <= '0;
            state   <= grant_d ? D_ACC : F_ACC;
          end
        end
        F_ACC, D_ACC: begin
          if (m_ready) begin
            if (state == F_ACC)  f_rdata <= m_rdata;
            else if (!m_we)      d_rdata <= m_rdata;
            f_valid <= (state == F_ACC);
            d_valid <= (state == D_ACC);
            m_req   <= 1'b0;
            cnt     <= '0;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            // silent memory: abort, flag it, hand the requester zeros
            if (state == F_ACC) f_rdata <= '0;
            else                d_rdata <= '0;
            f_valid <= (state == F_ACC);
            d_valid <= (state == D_ACC);
            err     <= 1'b1;
            m_req   <= 1'b0;
            cnt     <= '0;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected grants and responses are queued, checked by monitors.
module tb_unified_mem_arbiter;
  localparam int TO = 8;

  logic        clk, reset;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic        m_ready;
  logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;
  logic        f_valid, d_valid, stall_F, stall_M, m_req, m_we, err;
  logic [3:0]  m_be;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_valid(f_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_F(stall_F), .stall_M(stall_M),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;   // cycles into the access before m_ready; -1 = never
  } grant_t;

  grant_t      gq[$];
  logic [31:0] fq[$], dq[$];
  int          n_chk = 0, n_fail = 0;
  bit          stale = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event with nothing queued", name);
  endtask

  // memory model: checks granted fields every access cycle, answers after g.lat cycles
  initial begin
    grant_t g;
    bit     in_acc;
    int     cyc;
    in_acc = 0; cyc = 0;
    m_ready = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      m_ready = 0;
      if (!reset) begin
        in_acc = 0;
      end else if (m_req) begin
        if (!in_acc) begin
          in_acc = 1;
          cyc = 0;
          if (gq.size() == 0) begin
            unexpected("grant");
            g = '{addr: m_addr, we: m_we, be: m_be, wdata: m_wdata, rdata: 0, lat: 0};
          end else g = gq.pop_front();
        end
        check("m_addr", m_addr, g.addr);
        check("m_we", {31'b0, m_we}, {31'b0, g.we});
        check("m_be", {28'b0, m_be}, {28'b0, g.be});
        check("m_wdata", m_wdata, g.wdata);
        if (g.lat >= 0 && cyc == g.lat) begin
          m_ready = 1;
          m_rdata = g.rdata;
        end
        cyc++;
      end else begin
        if (in_acc && g.lat < 0) check("timeout_len", cyc, TO);
        in_acc = 0;
        if (stale) begin
          m_ready = 1;
          m_rdata = 32'hFFFF_FFFF;
          stale = 0;
        end
      end
    end
  end

  // response monitor
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (f_valid) begin
        check("stall_F_at_valid", {31'b0, stall_F}, 0);
        if (fq.size() == 0) unexpected("f_valid");
        else check("f_rdata", f_rdata, fq.pop_front());
      end
      if (d_valid) begin
        check("stall_M_at_valid", {31'b0, stall_M}, 0);
        if (dq.size() == 0) unexpected("d_valid");
        else check("d_rdata", d_rdata, dq.pop_front());
      end
    end
  end

  task automatic wait_done(input int budget);
    bit fd, dd;
    int i;
    fd = !f_req; dd = !d_req; i = 0;
    while (!(fd && dd) && i < budget) begin
      @(negedge clk);
      if (f_valid) fd = 1;
      if (d_valid) dd = 1;
      @(posedge clk); #1;
      if (fd) f_req = 0;
      if (dd) d_req = 0;
      i++;
    end
    if (!(fd && dd)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: no valid within %0d cycles", budget);
      f_req = 0; d_req = 0;
    end
  endtask

  task automatic data_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
    d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1;
  endtask

  initial begin
    reset = 1; f_req = 0; d_req = 0; d_we = 0; d_be = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0;
    #1 reset = 0;
    #2;
    check("rst_m_req", {31'b0, m_req}, 0);
    check("rst_f_valid", {31'b0, f_valid}, 0);
    check("rst_d_valid", {31'b0, d_valid}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_f_rdata", f_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #1 reset = 1;

    // reset while a fetch is in flight; the held request is granted afresh
    f_addr = 32'h10; f_req = 1;
    gq.push_back('{32'h10, 1'b0, 4'h0, 32'h0, 32'h0, -1});
    repeat (3) @(posedge clk);
    #1 check("mid_m_req", {31'b0, m_req}, 1);
    #2 reset = 0;
    #1;
    check("async_m_req", {31'b0, m_req}, 0);
    check("async_f_valid", {31'b0, f_valid}, 0);
    check("async_err", {31'b0, err}, 0);
    check("async_stall_F", {31'b0, stall_F}, 1);
    @(posedge clk); #1 reset = 1;
    gq.push_back('{32'h10, 1'b0, 4'h0, 32'h0, 32'h13, 0});
    fq.push_back(32'h13);
    wait_done(20);

    // single fetch, ready one cycle after m_req
    f_addr = 32'h40; f_req = 1;
    gq.push_back('{32'h40, 1'b0, 4'h0, 32'h0, 32'h0050_0093, 1});
    fq.push_back(32'h0050_0093);
    @(negedge clk) check("fetch_stall_F", {31'b0, stall_F}, 1);
    wait_done(20);

    // data read sets a known d_rdata
    data_req(1'b0, 4'hF, 32'h80, 32'h0);
    gq.push_back('{32'h80, 1'b0, 4'hF, 32'h0, 32'hCAFE_0001, 0});
    dq.push_back(32'hCAFE_0001);
    wait_done(20);

    // store leaves d_rdata alone
    data_req(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
    gq.push_back('{32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h5555_AAAA, 1});
    dq.push_back(32'hCAFE_0001);
    wait_done(20);

    // contention right after a data grant
`ifdef UMA_ROUND_ROBIN_EN
    gq.push_back('{32'h44, 1'b0, 4'h0, 32'h0, 32'h11, 0});
    gq.push_back('{32'h100, 1'b0, 4'hF, 32'h0, 32'h22, 0});
`else
    gq.push_back('{32'h100, 1'b0, 4'hF, 32'h0, 32'h22, 0});
    gq.push_back('{32'h44, 1'b0, 4'h0, 32'h0, 32'h11, 0});
`endif
    fq.push_back(32'h11);
    dq.push_back(32'h22);
    f_addr = 32'h44; f_req = 1;
    data_req(1'b0, 4'hF, 32'h100, 32'h0);
    wait_done(40);

    // silent memory: timeout, sticky err, zero data
    data_req(1'b0, 4'hF, 32'h300, 32'h0);
    gq.push_back('{32'h300, 1'b0, 4'hF, 32'h0, 32'h0, -1});
    dq.push_back(32'h0);
    wait_done(40);
    check("err_set", {31'b0, err}, 1);

    data_req(1'b0, 4'hF, 32'h304, 32'h0);
    gq.push_back('{32'h304, 1'b0, 4'hF, 32'h0, 32'h1234, 2});
    dq.push_back(32'h1234);
    wait_done(20);
    check("err_sticky", {31'b0, err}, 1);

    // stray m_ready while idle must be ignored
    stale = 1;
    repeat (4) @(posedge clk);
    #1;
    check("stale_f_rdata", f_rdata, 32'h11);
    check("stale_d_rdata", d_rdata, 32'h1234);
    check("stale_m_req", {31'b0, m_req}, 0);

    check("gq_drained", gq.size(), 0);
    check("fq_drained", fq.size(), 0);
    check("dq_drained", dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
